// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   mode_e      : the six display modes, encoded in 3 bits
//   NUM_MODES   : number of valid modes (mode wraps from NUM_MODES-1 to 0)
//   alt_base()  : alternating base pattern with the MSB set
package led_seq_pkg;

    typedef enum logic [2:0] {
        MODE_STATIC = 3'd0,
        MODE_GROUP  = 3'd1,
        MODE_OFF    = 3'd2,
        MODE_ALT    = 3'd3,
        MODE_CHASE  = 3'd4,
        MODE_BOUNCE = 3'd5
    } mode_e;

    localparam int NUM_MODES = 6;

    // Bit i is set when its distance from the MSB is even, so the MSB is
    // always lit regardless of whether led_w is odd or even.
    function automatic logic [31:0] alt_base(input int led_w);
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < led_w && ((led_w - 1 - i) % 2) == 0) begin
                a[i] = 1'b1;
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_in_sync_edge.sv
// in_sync_edge: conditions one asynchronous active-high button input.
//   clk      in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   async_in in  1  raw button level from the pin
//   pulse    out 1  registered one-cycle pulse, 3 cycles after the pin rises
// A held level yields a single pulse; the next pulse needs a release first.
module in_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        meta_d  = async_in;
        sync_d  = meta_q;
        prev_d  = sync_q;
        pulse_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: six-mode LED animation driver.
//   clk       in  1      system clock
//   reset_n   in  1      asynchronous active-low reset
//   in        in  1      mode-advance button (async, active-high)
//   start     in  1      run button (async, active-high)
//   pause     in  1      freeze button (async, active-high)
//   ledr      out LED_W  registered LED drive
//   mode      out 3      current mode 0..5
//   paused    out 1      display frozen
//   step_tick out 1      one-cycle pulse on each animation step
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int          LED_W      = 18,
    parameter int          TICK_DIV   = 25000000,
    parameter logic [31:0] STATIC_PAT = 32'h30,
    parameter logic [31:0] GROUP_PAT  = 32'h38CCC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             start,
    input  logic             pause,
    output logic [LED_W-1:0] ledr,
    output logic [2:0]       mode,
    output logic             paused,
    output logic             step_tick
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam int                POS_W    = $clog2(LED_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(LED_W - 1);
    localparam logic [LED_W-1:0]  STATIC_V = STATIC_PAT[LED_W-1:0];
    localparam logic [LED_W-1:0]  GROUP_V  = GROUP_PAT[LED_W-1:0];
    localparam logic [31:0]       ALT_FULL = alt_base(LED_W);
    localparam logic [LED_W-1:0]  ALT_V    = ALT_FULL[LED_W-1:0];
    localparam logic [LED_W-1:0]  BIT0     = {{(LED_W-1){1'b0}}, 1'b1};

    logic in_pulse, start_pulse, pause_pulse;

    mode_e            mode_q, mode_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_down_q, dir_down_d;
    logic [LED_W-1:0] ledr_q, ledr_d;

    logic             step;
    logic [POS_W-1:0] pos_inc, pos_dec;
    logic [LED_W-1:0] pat;

    in_sync_edge u_sync_in (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (in),
        .pulse    (in_pulse)
    );

    in_sync_edge u_sync_start (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (start),
        .pulse    (start_pulse)
    );

    in_sync_edge u_sync_pause (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (pause),
        .pulse    (pause_pulse)
    );

    assign step    = !paused_q && (cnt_q == CNT_MAX);
    assign pos_inc = pos_q + POS_W'(1);
    assign pos_dec = pos_q - POS_W'(1);

    // Run/pause flag: start has priority when both buttons land together.
    always_comb begin
        paused_d = paused_q;
        if (start_pulse) begin
            paused_d = 1'b0;
        end else if (pause_pulse) begin
            paused_d = 1'b1;
        end
    end

    // Mode, tick counter and animation state. A mode change restarts the
    // animation from its initial state even while paused.
    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        if (in_pulse) begin
            mode_d     = (mode_q == MODE_BOUNCE) ? MODE_STATIC : mode_e'(mode_q + 3'd1);
            cnt_d      = '0;
            phase_d    = 1'b0;
            pos_d      = '0;
            dir_down_d = 1'b0;
        end else if (!paused_q) begin
            if (step) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                if (mode_q == MODE_BOUNCE) begin
                    // Direction flips as an end is reached so ends show for one step.
                    if (!dir_down_q) begin
                        pos_d = pos_inc;
                        if (pos_inc == POS_MAX) dir_down_d = 1'b1;
                    end else begin
                        pos_d = pos_dec;
                        if (pos_dec == '0) dir_down_d = 1'b0;
                    end
                end else begin
                    pos_d = (pos_q == POS_MAX) ? '0 : pos_inc;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pattern selection; the output register freezes while paused.
    always_comb begin
        pat = '0;
        unique case (mode_q)
            MODE_STATIC: pat = STATIC_V;
            MODE_GROUP:  pat = phase_q ? ~GROUP_V : GROUP_V;
            MODE_OFF:    pat = '0;
            MODE_ALT:    pat = ALT_V ^ {LED_W{phase_q}};
            MODE_CHASE:  pat = BIT0 << pos_q;
            MODE_BOUNCE: pat = BIT0 << pos_q;
            default:     pat = '0;
        endcase
        ledr_d = paused_q ? ledr_q : pat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_STATIC;
            paused_q   <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            ledr_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            paused_q   <= paused_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            ledr_q     <= ledr_d;
        end
    end

    assign ledr      = ledr_q;
    assign mode      = mode_q;
    assign paused    = paused_q;
    assign step_tick = step;

endmodule
